// File: rtl/midi_rx.sv
// rtl/midi_rx.sv - MIDI 8N1 serial receiver with 8x oversampling, framing and overrun detection.
// Optional MIDI_RX_MAJORITY_EN: 2-of-3 majority vote per bit instead of a single mid-bit sample.
module midi_rx #(
  parameter int CLKS_PER_SAMPLE = 48
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  localparam logic [6:0] CNT_MAX = 7'(CLKS_PER_SAMPLE - 1);

  state_t      state, state_nx;
  logic        rx_m, rx_s;
  logic [6:0]  cnt;
  logic [2:0]  phase;
  logic [3:0]  bitn;
  logic [7:0]  shreg;
  logic        tick, decide, bit_val, load, ferr_set;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign tick = (state != IDLE) && (cnt == CNT_MAX);

`ifdef MIDI_RX_MAJORITY_EN
  // Samples at phases 2 and 3 are held; the third vote is the live sample at phase 4.
  logic s_a, s_b;
  assign decide  = tick && (phase == 3'd4);
  assign bit_val = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_a <= 1'b1;
      s_b <= 1'b1;
    end else if (tick) begin
      if (phase == 3'd2) s_a <= rx_s;
      if (phase == 3'd3) s_b <= rx_s;
    end
  end
`else
  assign decide  = tick && (phase == 3'd3);
  assign bit_val = rx_s;
`endif

  // phase = tick position within the bit, bitn = bit index (0 start .. 9 stop)
  always_ff @(posedge clk) begin
    if (!rst_n || state == IDLE) begin
      cnt   <= '0;
      phase <= '0;
      bitn  <= '0;
    end else if (tick) begin
      cnt   <= '0;
      phase <= phase + 3'd1;
      if (phase == 3'd7) bitn <= bitn + 4'd1;
    end else begin
      cnt <= cnt + 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    ferr_set = 1'b0;
    case (state)
      IDLE:  if (!rx_s) state_nx = START;
      START: if (decide) state_nx = bit_val ? IDLE : DATA;
      DATA:  if (decide && bitn == 4'd8) state_nx = STOP;
      STOP: begin
        if (decide) begin
          if (bit_val) begin
            load     = 1'b1;
            state_nx = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_nx = BREAK;
          end
        end
      end
      BREAK: if (rx_s) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) shreg <= '0;
    else if (decide && state == DATA) shreg <= {bit_val, shreg[7:1]};
  end

  // A completing byte wins over a same-cycle acknowledge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      if (load) begin
        data       <= shreg;
        data_valid <= 1'b1;
        if (rd && data_valid)  overrun <= 1'b0;
        else if (data_valid)   overrun <= 1'b1;
      end else if (rd && data_valid) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_midi_rx.sv
// tb/tb_midi_rx.sv - Self-checking bench for midi_rx: event-level model plus directed frames.
module tb_midi_rx;
  localparam int C    = 48;
  localparam int BITC = 8 * C;
`ifdef MIDI_RX_MAJORITY_EN
  localparam int DT  = 77;
  localparam int LAT = 3697;
`else
  localparam int DT  = 76;
  localparam int LAT = 3649;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] data;
  logic       data_valid, frame_err, overrun, busy;

  midi_rx #(.CLKS_PER_SAMPLE(C)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rd(rd),
    .data(data), .data_valid(data_valid), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0, printed = 0;

  // Model: scheduled frame outcome and busy window, set by the stimulus tasks.
  logic [7:0] m_data = 8'h00;
  logic       m_valid = 1'b0, m_ovr = 1'b0;
  int         busy_from = -1, busy_to = -2, ev_cyc = -1, last_T = 0;
  bit         ev_ferr = 1'b0;
  logic [7:0] ev_byte = 8'h00;
  bit         rst_prev = 1'b0, rd_prev = 1'b0, chk_en = 1'b0;
  int         ferr_cnt = 0, last_rise = -1;
  logic       dv_q = 1'b0;

  always @(negedge clk) begin
    bit m_ferr, m_busy, byte_ev;
    m_ferr  = 1'b0;
    byte_ev = 1'b0;
    if (!rst_prev) begin
      m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0;
      ev_cyc = -1; busy_from = -1; busy_to = -2;
    end else begin
      byte_ev = (ev_cyc == cyc) && !ev_ferr;
      m_ferr  = (ev_cyc == cyc) && ev_ferr;
      if (byte_ev) begin
        if (m_valid && !rd_prev)      m_ovr = 1'b1;
        else if (rd_prev && m_valid)  m_ovr = 1'b0;
        m_data  = ev_byte;
        m_valid = 1'b1;
      end else if (rd_prev && m_valid) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
    end
    m_busy = (cyc >= busy_from) && (cyc <= busy_to);
    if (chk_en) begin
      tests++;
      if ({data, data_valid, frame_err, overrun, busy} !==
          {m_data, m_valid, m_ferr, m_ovr, m_busy}) begin
        fails++;
        if (printed < 20) begin
          printed++;
          $display("FAIL cycle_model @%0d: got data=%h dv=%b fe=%b ov=%b busy=%b, expected data=%h dv=%b fe=%b ov=%b busy=%b",
                   cyc, data, data_valid, frame_err, overrun, busy,
                   m_data, m_valid, m_ferr, m_ovr, m_busy);
        end
      end
    end
    if (frame_err === 1'b1) ferr_cnt++;
    if (data_valid === 1'b1 && dv_q !== 1'b1) last_rise = cyc;
    dv_q     = data_valid;
    rst_prev = rst_n;
    rd_prev  = rd;
  end

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    tick_clk();
    rd = 1'b0;
  endtask

  // Drives one 8N1 frame; rd_first acknowledges during the start cycle, cut>0 aborts after cut cycles.
  task automatic send_byte(input logic [7:0] b, input bit stop, input bit rd_first, input int cut);
    logic [9:0] fr;
    int p, t, n;
    fr = {stop, b, 1'b0};
    p = cyc;
    t = p + 2;
    last_T    = t;
    busy_from = t + 1;
    busy_to   = stop ? t + DT * C : (1 << 30);
    ev_cyc    = t + DT * C + 1;
    ev_ferr   = !stop;
    ev_byte   = b;
    if (rd_first) rd = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      for (int k = 0; k < BITC; k++) begin
        tick_clk();
        rd = 1'b0;
        n++;
        if (cut != 0 && n == cut) return;
      end
    end
  endtask

  initial begin
    int t90, p;
    repeat (3) tick_clk();
    rst_n  = 1'b1;
    chk_en = 1'b1;
    chk("reset_data", 32'(data), 32'h00);
    chk("reset_flags", {28'd0, data_valid, frame_err, overrun, busy}, 32'h0);
    repeat (10) tick_clk();

    send_byte(8'h90, 1'b1, 1'b0, 0);
    t90 = last_T;
    repeat (20) tick_clk();
    chk("latency_0x90", 32'(last_rise - t90), 32'(LAT));
    chk("data_0x90", 32'(data), 32'h90);
    chk("flags_0x90", {30'd0, frame_err, overrun}, 32'h0);
    pulse_rd();
    chk("rd_clears_dv", 32'(data_valid), 32'h0);

    send_byte(8'h90, 1'b1, 1'b0, 0);
    chk("seq_0x90", 32'(data), 32'h90);
    send_byte(8'h3C, 1'b1, 1'b1, 0);
    chk("seq_0x3C", 32'(data), 32'h3C);
    send_byte(8'h7F, 1'b1, 1'b1, 0);
    chk("seq_0x7F", 32'(data), 32'h7F);
    chk("seq_no_ovr", 32'(overrun), 32'h0);
    pulse_rd();
    chk("seq_dv_clear", 32'(data_valid), 32'h0);

    repeat (5) tick_clk();
    send_byte(8'h55, 1'b1, 1'b0, 0);
    send_byte(8'hAA, 1'b1, 1'b0, 0);
    chk("ovr_data", 32'(data), 32'hAA);
    chk("ovr_flags", {30'd0, data_valid, overrun}, 32'h3);
    pulse_rd();
    chk("ovr_cleared", {30'd0, data_valid, overrun}, 32'h0);

    repeat (5) tick_clk();
    chk("ferr_none_yet", 32'(ferr_cnt), 32'd0);
    send_byte(8'h41, 1'b0, 1'b0, 0);
    repeat (24000) tick_clk();
    chk("break_busy", 32'(busy), 32'h1);
    rx = 1'b1;
    busy_to = cyc + 2;
    repeat (10) tick_clk();
    chk("break_one_ferr", 32'(ferr_cnt), 32'd1);
    chk("break_data_kept", 32'(data), 32'hAA);
    chk("break_idle", {30'd0, busy, data_valid}, 32'h0);

    p = cyc;
    busy_from = p + 3;
    busy_to   = p + 2 + (DT - 72) * C;
    rx = 1'b0;
    repeat (120) tick_clk();
    rx = 1'b1;
    repeat (400) tick_clk();
    chk("glitch_no_dv", 32'(data_valid), 32'h0);
    chk("glitch_no_ferr", 32'(ferr_cnt), 32'd1);
    chk("glitch_idle", 32'(busy), 32'h0);

    send_byte(8'hF8, 1'b1, 1'b0, 5 * BITC + BITC / 2);
    chk("midframe_busy", 32'(busy), 32'h1);
    rx    = 1'b1;
    rst_n = 1'b0;
    tick_clk();
    rst_n = 1'b1;
    chk("midreset_data", 32'(data), 32'h00);
    chk("midreset_flags", {28'd0, data_valid, frame_err, overrun, busy}, 32'h0);
    repeat (100) tick_clk();
    send_byte(8'hF8, 1'b1, 1'b0, 0);
    chk("after_reset_0xF8", {24'd0, data}, 32'hF8);
    chk("after_reset_dv", {30'd0, data_valid, overrun}, 32'h2);
    pulse_rd();
    repeat (5) tick_clk();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/midi_rx.md
# midi_rx

MIDI serial receiver for the 12 MHz single-clock design. Recovers 8N1 bytes at 31250 baud from the raw MIDI input pin using an internally generated 8x oversample tick, so no derived clocks are required. Presents each received byte with a level valid flag held until the consumer acknowledges it, and reports framing and overrun errors. Sits between the opto-isolated MIDI IN pin and the MIDI message parser.

## Interface
- CLKS_PER_SAMPLE, 48, clk cycles per oversample tick (12 MHz / (31250 × 8)); 7-bit counter, legal range 2–127
- clk  input  1  system clock, 12 MHz, all logic on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- rx  input  1  asynchronous MIDI serial line, idle high
- rd  input  1  consumer acknowledge, one-cycle pulse
- data  output  8  last good received byte
- data_valid  output  1  data holds an unread byte
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  sticky: a byte was overwritten before being read
- busy  output  1  high in any state other than IDLE

## Operation
- rx passes through a 2-flop synchronizer (both flops reset to 1) producing rx_s; only rx_s is used.
- Tick counter counts 0..CLKS_PER_SAMPLE-1; tick pulses when counter equals CLKS_PER_SAMPLE-1. Counter forced to 0 in the cycle IDLE sees rx_s low; it does not count in IDLE.
- Tick index n = ticks since start detection, n = 1 is the first tick; bit b (0 = start, 1..8 = data LSB first, 9 = stop) occupies ticks 8b+1..8b+8.
- Bit decision at tick 8b+4 (single sample at that tick).
- States: IDLE, START, DATA, STOP, BREAK.
  - IDLE: rx_s low → START, clear tick counter and bit counter.
  - START: at decision tick, bit 1 → IDLE (glitch rejected, no flags); 0 → DATA.
  - DATA: at each decision tick shift bit into shift register at bit 7, shift right; after bit 8 → STOP.
  - STOP: at decision tick, 1 → load data, set data_valid, → IDLE; 0 → pulse frame_err, data unchanged, → BREAK.
  - BREAK: wait until rx_s high, → IDLE (a held-low break line produces exactly one frame_err).
- rd with data_valid high clears data_valid and overrun in the next cycle; rd with data_valid low is ignored.
- New byte completing while data_valid is high: data overwritten, data_valid stays high, overrun set.
- Same cycle rd and new byte completion: the new byte wins; data_valid stays high, overrun not set.

## Timing
- Reset values: data = 8'h00, data_valid = 0, frame_err = 0, overrun = 0, busy = 0; state IDLE, counters 0.
- Reset asserted mid-frame aborts the frame; no partial byte or flag emitted.
- Let T = cycle IDLE sees rx_s low (pin edge + 2 cycles). Tick n at T + n·CLKS_PER_SAMPLE.
- Stop decision at tick 76; data/data_valid update visible at T + 76·CLKS_PER_SAMPLE + 1 (T+3649 at default). frame_err pulses in the same cycle position.
- IDLE is re-entered at that cycle; back-to-back start bit is accepted immediately (stop-bit tail overlap tolerated).
- busy goes high at T+1, low when IDLE is re-entered.

## Configuration
- MIDI_RX_MAJORITY_EN defined: each bit is a 2-of-3 majority of samples at ticks 8b+3, 8b+4, 8b+5; decision at 8b+5; data_valid at T + 77·CLKS_PER_SAMPLE + 1 (T+3697). Start-bit glitch rejection uses the majority value.
- Undefined: single sample at tick 8b+4 as above; no extra sample registers.

## Test plan
- Send 0x90 at 31250 baud, 8N1 → data = 8'h90, data_valid rises at T+3649, frame_err and overrun stay 0; rd → data_valid 0 next cycle.
- Send 0x90, 0x3C, 0x7F back-to-back, rd after each → three bytes in order, no errors.
- Send 0x55 then 0xAA without rd → data = 8'hAA, data_valid 1, overrun 1; rd clears both.
- Send 0x41 with stop bit forced low, then hold line low 2 ms → single frame_err pulse, data unchanged, busy high until line returns high.
- 10 µs low glitch on idle line → no data_valid, no frame_err, busy returns 0 after tick 4.
- Assert rst_n low during bit 5 of 0xF8 → all outputs at reset values next cycle; following 0xF8 received correctly.
